// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared defaults, state encoding and majority vote for the UART receive controller
package uart_rx_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial input and bit-strobe outputs of the UART receive controller
interface uart_rx_ctrl_if;
    logic rx_tick;
    logic rx;
    logic shift;
    logic serial_out;
    logic busy;
    logic rx_done;
    logic frame_err;
    logic parity_err;

    modport master (
        input  rx_tick, rx,
        output shift, serial_out, busy, rx_done, frame_err, parity_err
    );

    modport slave (
        output rx_tick, rx,
        input  shift, serial_out, busy, rx_done, frame_err, parity_err
    );
endinterface

// File: rtl/uart_rx_ctrl_rx_sync.sv
// rtl/uart_rx_ctrl_rx_sync.sv - two-flop rx synchroniser with armed falling-edge start detect
module rx_sync (
    input  logic rx_clk,
    input  logic rst,
    input  logic rx,
    input  logic in_idle,
    input  logic stop_arm,
    output logic rx_s,
    output logic start_det
);
    logic rx_m;
    logic armed;

    // armed only comes back after a high line, so a stuck-low rx cannot retrigger
    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            rx_m  <= 1'b0;
            rx_s  <= 1'b0;
            armed <= 1'b0;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            if (start_det)
                armed <= 1'b0;
            else if (stop_arm || (in_idle && rx_s))
                armed <= 1'b1;
        end
    end

    assign start_det = in_idle && armed && !rx_s;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive bit-timing FSM: mid-bit majority sampling, shift strobes, parity and stop checks
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            rx_clk,
    input  logic            rst,
    uart_rx_ctrl_if.master  bus
);
    localparam int M   = OVERSAMPLE / 2;
    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_WIDTH + 1);

    localparam logic [TCW-1:0] TC_S0   = TCW'(M - 1);
    localparam logic [TCW-1:0] TC_S1   = TCW'(M);
    localparam logic [TCW-1:0] TC_DEC  = TCW'(M + 1);
    localparam logic [TCW-1:0] TC_END  = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);

    rx_state_t      state;
    logic [TCW-1:0] tc;
    logic [BCW-1:0] bc;
    logic           smp0, smp1;
    logic           par, par_res;
    logic           shift_r, serial_out_r, busy_r, rx_done_r, frame_err_r, parity_err_r;

    logic rx_s, start_det;
    logic bit_val, decide, bit_end, stop_arm;

    assign bit_val  = maj3(smp0, smp1, rx_s);
    assign decide   = bus.rx_tick && (tc == TC_DEC);
    assign bit_end  = bus.rx_tick && (tc == TC_END);
    assign stop_arm = (state == STOP) && decide && bit_val;

    rx_sync u_rx_sync (
        .rx_clk    (rx_clk),
        .rst       (rst),
        .rx        (bus.rx),
        .in_idle   (state == IDLE),
        .stop_arm  (stop_arm),
        .rx_s      (rx_s),
        .start_det (start_det)
    );

    always_ff @(posedge rx_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            tc           <= '0;
            bc           <= '0;
            smp0         <= 1'b0;
            smp1         <= 1'b0;
            par          <= 1'b0;
            par_res      <= 1'b0;
            shift_r      <= 1'b0;
            serial_out_r <= 1'b0;
            busy_r       <= 1'b0;
            rx_done_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            shift_r   <= 1'b0;
            rx_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state  <= START;
                        tc     <= '0;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    if (bus.rx_tick) begin
                        tc <= bit_end ? '0 : tc + 1'b1;
                        if (tc == TC_S0) smp0 <= rx_s;
                        if (tc == TC_S1) smp1 <= rx_s;
                        case (state)
                            START: begin
                                if (decide && bit_val) begin
                                    state  <= IDLE;
                                    tc     <= '0;
                                    busy_r <= 1'b0;
                                end else if (bit_end) begin
                                    state <= DATA;
                                    bc    <= '0;
                                end
                            end
                            DATA: begin
                                if (decide) begin
                                    serial_out_r <= bit_val;
                                    shift_r      <= 1'b1;
                                    par          <= par ^ bit_val;
                                end
                                if (bit_end) begin
                                    bc <= bc + 1'b1;
                                    if (bc == BC_LAST)
                                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                                end
                            end
                            PARITY: begin
                                // mismatch when received bit differs from expected (par, inverted for odd)
                                if (decide)
                                    par_res <= bit_val ^ par ^ (PARITY_ODD != 0);
                                if (bit_end)
                                    state <= STOP;
                            end
                            STOP: begin
                                // leave at the decision so a start in the stop bit's second half is caught
                                if (decide) begin
                                    rx_done_r    <= 1'b1;
                                    frame_err_r  <= ~bit_val;
                                    parity_err_r <= (PARITY_EN != 0) && par_res;
                                    par          <= 1'b0;
                                    par_res      <= 1'b0;
                                    state        <= IDLE;
                                    tc           <= '0;
                                    busy_r       <= 1'b0;
                                end
                            end
                            default: begin
                                state  <= IDLE;
                                busy_r <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.shift      = shift_r;
    assign bus.serial_out = serial_out_r;
    assign bus.busy       = busy_r;
    assign bus.rx_done    = rx_done_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.parity_err = parity_err_r;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl (8N1 instance and even-parity instance)
module tb_uart_rx_ctrl;
    logic clk;
    logic rst;
    logic tick;
    logic rx_a;
    logic rx_p;
    int   tdiv;

    int errors;
    int checks;

    int shift_cnt, done_cnt, dbl_cnt, pshift_cnt, pdone_cnt;
    logic busy_at_done;
    logic prev_shift;
    logic bits[$];

    uart_rx_ctrl_if bus ();
    uart_rx_ctrl_if pbus ();

    assign bus.rx_tick  = tick;
    assign pbus.rx_tick = tick;
    assign bus.rx       = rx_a;
    assign pbus.rx      = rx_p;

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    uart_rx_ctrl #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .rx_clk (clk),
        .rst    (rst),
        .bus    (pbus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // one rx_tick every 4 rx_clk cycles -> 64 clocks per bit
    initial begin
        tick = 1'b0;
        tdiv = 0;
        forever begin
            @(negedge clk);
            tdiv = (tdiv == 3) ? 0 : tdiv + 1;
            tick = (tdiv == 0);
        end
    end

    initial begin
        shift_cnt = 0; done_cnt = 0; dbl_cnt = 0; pshift_cnt = 0; pdone_cnt = 0;
        busy_at_done = 1'b1;
        prev_shift = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.shift === 1'b1) begin
                shift_cnt++;
                bits.push_back(bus.serial_out);
                if (prev_shift) dbl_cnt++;
            end
            prev_shift = (bus.shift === 1'b1);
            if (bus.rx_done === 1'b1) begin
                done_cnt++;
                busy_at_done = bus.busy;
            end
            if (pbus.shift === 1'b1) pshift_cnt++;
            if (pbus.rx_done === 1'b1) pdone_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic b, input int n);
        if (sel) rx_p = b; else rx_a = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input bit use_par,
                              input logic par_bit, input logic stop_bit, input int stop_ticks);
        drive_bit(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(sel, data[i], 16);
        if (use_par) drive_bit(sel, par_bit, 16);
        drive_bit(sel, stop_bit, stop_ticks);
        if (sel) rx_p = 1'b1; else rx_a = 1'b1;
    endtask

    task automatic take_bits(output logic [15:0] v, output int n);
        n = bits.size();
        v = '0;
        for (int i = 0; i < n && i < 16; i++) v[i] = bits[i];
        bits.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx_a = 1'b1;
        rx_p = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.shift, bus.serial_out, bus.busy, bus.rx_done, bus.frame_err, bus.parity_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bus.shift, bus.serial_out, bus.busy, bus.rx_done, bus.frame_err, bus.parity_err});
        end
        rst = 1'b0;
        wait_ticks(8);
        checks++;
        if ({bus.busy, bus.rx_done, pbus.busy, pbus.parity_err} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {bus.busy, bus.rx_done, pbus.busy, pbus.parity_err});
        end
    endtask

    task automatic test_8n1;
        int s0, d0, n;
        logic [15:0] v;
        s0 = shift_cnt; d0 = done_cnt;
        bits.delete();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        take_bits(v, n);
        checks++;
        if (shift_cnt - s0 !== 8) begin errors++; $display("FAIL a5_shift_count: got %0d expected 8", shift_cnt - s0); end
        checks++;
        if (v[7:0] !== 8'hA5) begin errors++; $display("FAIL a5_bits: got %h expected a5", v[7:0]); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL a5_rx_done: got %0d expected 1", done_cnt - d0); end
        checks++;
        if ({bus.frame_err, bus.parity_err} !== 2'b00) begin
            errors++; $display("FAIL a5_errors: got %b expected 00", {bus.frame_err, bus.parity_err});
        end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL a5_busy_at_done: got %b expected 0", busy_at_done); end
        checks++;
        if (dbl_cnt !== 0) begin errors++; $display("FAIL shift_one_cycle: got %0d wide pulses expected 0", dbl_cnt); end
    endtask

    task automatic test_glitch;
        int s0, d0, n;
        logic [15:0] v;
        s0 = shift_cnt; d0 = done_cnt;
        rx_a = 1'b0;
        wait_ticks(4);
        rx_a = 1'b1;
        wait_ticks(4);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_mid: got %b expected 1", bus.busy); end
        wait_ticks(3);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b expected 0", bus.busy); end
        wait_ticks(8);
        checks++;
        if ({shift_cnt - s0, done_cnt - d0} !== {32'd0, 32'd0}) begin
            errors++; $display("FAIL glitch_no_activity: shifts %0d done %0d expected 0 0", shift_cnt - s0, done_cnt - d0);
        end
        bits.delete();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        take_bits(v, n);
        checks++;
        if (n !== 8 || v[7:0] !== 8'h3C) begin
            errors++; $display("FAIL glitch_next_frame: got %0d bits %h expected 8 bits 3c", n, v[7:0]);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_next_done: got %0d expected 1", done_cnt - d0); end
    endtask

    task automatic test_held_low;
        int s0, d0, n;
        logic [15:0] v;
        s0 = shift_cnt; d0 = done_cnt;
        bits.delete();
        send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16);
        rx_a = 1'b0;
        wait_ticks(40 * 16);
        take_bits(v, n);
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL low_done_count: got %0d expected 1", done_cnt - d0); end
        checks++;
        if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL low_frame_err: got %b expected 1", bus.frame_err); end
        checks++;
        if (n !== 8 || v[7:0] !== 8'h00 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL low_no_retrigger: got %0d bits %h busy %b expected 8 bits 00 busy 0", n, v[7:0], bus.busy);
        end
        rx_a = 1'b1;
        wait_ticks(16);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        take_bits(v, n);
        checks++;
        if (n !== 8 || v[7:0] !== 8'h81) begin
            errors++; $display("FAIL low_recover_bits: got %0d bits %h expected 8 bits 81", n, v[7:0]);
        end
        checks++;
        if (bus.frame_err !== 1'b0 || done_cnt - d0 !== 2) begin
            errors++; $display("FAIL low_recover_err: frame_err %b done %0d expected 0 2", bus.frame_err, done_cnt - d0);
        end
    endtask

    task automatic test_parity;
        int s0, d0;
        s0 = pshift_cnt; d0 = pdone_cnt;
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 16);
        wait_ticks(4);
        checks++;
        if (pbus.parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", pbus.parity_err); end
        checks++;
        if (pdone_cnt - d0 !== 1 || pshift_cnt - s0 !== 8 || pbus.frame_err !== 1'b0) begin
            errors++; $display("FAIL parity_frame: done %0d shifts %0d frame_err %b expected 1 8 0",
                               pdone_cnt - d0, pshift_cnt - s0, pbus.frame_err);
        end
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 16);
        wait_ticks(4);
        checks++;
        if (pbus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", pbus.parity_err); end
        checks++;
        if (pdone_cnt - d0 !== 2 || pshift_cnt - s0 !== 16) begin
            errors++; $display("FAIL parity_counts: done %0d shifts %0d expected 2 16", pdone_cnt - d0, pshift_cnt - s0);
        end
    endtask

    task automatic test_reset_mid;
        int s0, d0, n;
        logic [15:0] v;
        s0 = shift_cnt; d0 = done_cnt;
        drive_bit(1'b0, 1'b0, 16);
        drive_bit(1'b0, 1'b1, 16 * 2 + 12);
        checks++;
        if (shift_cnt - s0 !== 3) begin errors++; $display("FAIL mid_three_shifts: got %0d expected 3", shift_cnt - s0); end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.shift, bus.serial_out, bus.busy, bus.rx_done, bus.frame_err, bus.parity_err} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b expected 000000",
                     {bus.shift, bus.serial_out, bus.busy, bus.rx_done, bus.frame_err, bus.parity_err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(16);
        checks++;
        if (done_cnt - d0 !== 0) begin errors++; $display("FAIL mid_no_partial_done: got %0d expected 0", done_cnt - d0); end
        bits.delete();
        s0 = shift_cnt;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        take_bits(v, n);
        checks++;
        if (shift_cnt - s0 !== 8 || v[7:0] !== 8'h5A) begin
            errors++; $display("FAIL mid_next_frame: got %0d shifts bits %h expected 8 shifts bits 5a", shift_cnt - s0, v[7:0]);
        end
    endtask

    task automatic test_back_to_back;
        int s0, d0, n;
        logic [15:0] v;
        s0 = shift_cnt; d0 = done_cnt;
        bits.delete();
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 11);
        send_frame(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 16);
        wait_ticks(4);
        take_bits(v, n);
        checks++;
        if (shift_cnt - s0 !== 16) begin errors++; $display("FAIL b2b_shift_count: got %0d expected 16", shift_cnt - s0); end
        checks++;
        if (v !== 16'hAA55) begin errors++; $display("FAIL b2b_bits: got %h expected aa55", v); end
        checks++;
        if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
        checks++;
        if ({bus.frame_err, bus.parity_err} !== 2'b00 || dbl_cnt !== 0) begin
            errors++; $display("FAIL b2b_errors: got %b wide %0d expected 00 0", {bus.frame_err, bus.parity_err}, dbl_cnt);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        rx_a = 1'b1;
        rx_p = 1'b1;
        test_reset();
        test_8n1();
        test_glitch();
        test_held_low();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
